mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 20 ++
 rtl/mult_arb_pick.sv | 33 +++
 rtl/mult_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared FSM state type and default sizes for mult_arbiter
//
// Contents:
//   DEF_WIDTH    default operand width
//   DEF_N_REQ    default number of requesters
//   arb_state_t  arbiter FSM states
package mult_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mult_arb_pick.sv
// rtl/mult_arb_pick.sv - combinational one-hot winner selection starting at a search pointer
//
// Ports:
//   req  in   N_REQ   request vector
//   ptr  in   PTR_W   first index searched (tie to 0 for fixed priority)
//   gnt  out  N_REQ   one-hot winner, zero when req is zero
module mult_arb_pick
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest set request
  // after ptr is the last one written and therefore wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        gnt = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - arbitrates N_REQ requesters onto one shared multiplier
//
// Optional feature: define MULT_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer register.
//
// Ports:
//   clk_i         in   1            clock, rising edge
//   rst_i         in   1            asynchronous active-high reset
//   req_i         in   N_REQ        level requests, held until done
//   a_bi, b_bi    in   N_REQ*WIDTH  packed operands, slice i = requester i
//   done_o        out  N_REQ        one-hot one-cycle completion pulse
//   y_bo          out  2*WIDTH      last result, held until next completion
//   gnt_o         out  N_REQ        one-hot owner of the operation in flight
//   mult_start_o  out  1            start pulse to the multiplier
//   mult_a_bo     out  WIDTH        registered operand A to the multiplier
//   mult_b_bo     out  WIDTH        registered operand B to the multiplier
//   mult_y_bi     in   2*WIDTH      multiplier result
//   mult_busy_i   in   1            multiplier busy flag
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] a_bi,
  input  logic [N_REQ*WIDTH-1:0] b_bi,
  output logic [N_REQ-1:0]       done_o,
  output logic [2*WIDTH-1:0]     y_bo,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   mult_start_o,
  output logic [WIDTH-1:0]       mult_a_bo,
  output logic [WIDTH-1:0]       mult_b_bo,
  input  logic [2*WIDTH-1:0]     mult_y_bi,
  input  logic                   mult_busy_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] search_ptr;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             grant_en, capture_en;

  assign grant_en   = (state_q == IDLE) && (|req_i) && !mult_busy_i;
  assign capture_en = (state_q == WAIT_DONE) && !mult_busy_i;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  // Pointer holds the first index to search next time: one past the winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (grant_en) begin
      rr_ptr_q <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign search_ptr = rr_ptr_q;
`else
  assign search_ptr = '0;
`endif

  mult_arb_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_i),
    .ptr (search_ptr),
    .gnt (pick_gnt)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = a_bi[i*WIDTH +: WIDTH];
        sel_b = b_bi[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mult_start_o = 1'b0;
    done_o       = '0;
    unique case (state_q)
      IDLE:      if (grant_en) state_d = ISSUE;
      ISSUE: begin
        mult_start_o = 1'b1;
        state_d      = WAIT_BUSY;
      end
      WAIT_BUSY: if (mult_busy_i) state_d = WAIT_DONE;
      WAIT_DONE: if (!mult_busy_i) state_d = DONE;
      DONE: begin
        done_o  = gnt_o;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Operands are captured only at grant, so later changes on a_bi/b_bi or a
  // dropped request cannot disturb the operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_o     <= '0;
      mult_a_bo <= '0;
      mult_b_bo <= '0;
      y_bo      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        gnt_o     <= pick_gnt;
        mult_a_bo <= sel_a;
        mult_b_bo <= sel_b;
      end else if (state_q == DONE) begin
        gnt_o <= '0;
      end
      if (capture_en) begin
        y_bo <= mult_y_bi;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*W-1:0]  a_bi;
  logic [N*W-1:0]  b_bi;
  logic [N-1:0]    done_o;
  logic [2*W-1:0]  y_bo;
  logic [N-1:0]    gnt_o;
  logic            mult_start_o;
  logic [W-1:0]    mult_a_bo;
  logic [W-1:0]    mult_b_bo;
  logic [2*W-1:0]  mult_y_bi;
  logic            mult_busy_i;

  logic            mdl_busy;
  logic            force_busy;
  logic [2*W-1:0]  mdl_y;
  logic            pending;
  int              cnt;
  int              busy_len;
  logic [W-1:0]    ma, mb;

  int n_cmp;
  int n_fail;
  int start_cnt;
  int done_cnt;
  int model_first;

  logic [N-1:0]    prev_gnt;
  logic [W-1:0]    prev_a, prev_b;

  assign mult_busy_i = mdl_busy | force_busy;
  assign mult_y_bi   = mdl_y;

  mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .a_bi         (a_bi),
    .b_bi         (b_bi),
    .done_o       (done_o),
    .y_bo         (y_bo),
    .gnt_o        (gnt_o),
    .mult_start_o (mult_start_o),
    .mult_a_bo    (mult_a_bo),
    .mult_b_bo    (mult_b_bo),
    .mult_y_bi    (mult_y_bi),
    .mult_busy_i  (mult_busy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Shared multiplier: busy starts the cycle after the start pulse, lasts
  // busy_len cycles, and the result is garbage until busy falls.
  initial begin
    mdl_busy = 1'b0;
    mdl_y    = '0;
    pending  = 1'b0;
    cnt      = 0;
    ma       = '0;
    mb       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        mdl_busy = 1'b0;
        pending  = 1'b0;
        cnt      = 0;
      end else begin
        if (pending) begin
          mdl_busy = 1'b1;
          cnt      = busy_len;
          pending  = 1'b0;
          mdl_y    = 16'($urandom);
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mdl_busy = 1'b0;
            mdl_y    = {8'b0, ma} * {8'b0, mb};
          end
        end
        if (mult_start_o) begin
          pending = 1'b1;
          ma      = mult_a_bo;
          mb      = mult_b_bo;
        end
      end
    end
  end

  initial begin
    start_cnt = 0;
    done_cnt  = 0;
    prev_gnt  = '0;
    prev_a    = '0;
    prev_b    = '0;
    forever begin
      @(negedge clk);
      if (mult_start_o) start_cnt++;
      if (done_o != '0) begin
        done_cnt++;
        chk("done_onehot", 32'($onehot(done_o)), 1);
      end
      if (gnt_o != '0 && gnt_o == prev_gnt) begin
        chk("op_a_stable", mult_a_bo, prev_a);
        chk("op_b_stable", mult_b_bo, prev_b);
      end
      prev_gnt = gnt_o;
      prev_a   = mult_a_bo;
      prev_b   = mult_b_bo;
    end
  end

  // Winner = first set request at or after 'first', found by rotating the
  // request vector and isolating its lowest set bit.
  function automatic int model_pick(input logic [N-1:0] req, input int first);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot, low;
    int             pos;
    dbl = {req, req} >> first;
    rot = dbl[N-1:0];
    low = rot & (~rot + 1'b1);
    pos = 0;
    for (int k = 0; k < N; k++) if (low[k]) pos = k;
    return (pos + first) % N;
  endfunction

  task automatic advance(input int idx);
`ifdef MULT_ARB_ROUND_ROBIN_EN
    model_first = (idx + 1) % N;
`else
    model_first = 0;
    if (idx < 0) model_first = 0;
`endif
  endtask

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b, input int idx);
    return ((a >> (8 * idx)) & 32'hFF) * ((b >> (8 * idx)) & 32'hFF);
  endfunction

  task automatic wait_done(output logic [N-1:0] d, output logic [2*W-1:0] y, output bit ok);
    ok = 1'b0;
    d  = '0;
    y  = '0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (done_o != '0) begin
        ok = 1'b1;
        d  = done_o;
        y  = y_bo;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_done: got no done pulse in 200 cycles, required one");
    end
  endtask

  task automatic do_op(input string name, input logic [N-1:0] req,
                       input logic [31:0] a, input logic [31:0] b, input int exp_idx);
    int             s0;
    logic [N-1:0]   d;
    logic [2*W-1:0] y;
    bit             ok;
    s0    = start_cnt;
    req_i = req;
    a_bi  = a;
    b_bi  = b;
    wait_done(d, y, ok);
    req_i = '0;
    if (ok) begin
      chk({name, "_done"}, d, 32'(1) << exp_idx);
      chk({name, "_y"}, y, prod(a, b, exp_idx));
      chk({name, "_starts"}, start_cnt - s0, 1);
    end
    advance(exp_idx);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_first = 0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  a;
    logic [31:0]  b;
    int           exp_fp;
    int           exp_rr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int             e;
    int             s0;
    int             d0;
    int             hexp[5];
    logic [N-1:0]   hreq;
    logic [N-1:0]   d;
    logic [2*W-1:0] y;
    bit             ok;
    logic [N-1:0]   r;
    logic [31:0]    ra, rb;

    n_cmp       = 0;
    n_fail      = 0;
    model_first = 0;
    busy_len    = 8;
    force_busy  = 1'b0;
    rst_i       = 1'b1;
    req_i       = '0;
    a_bi        = '0;
    b_bi        = '0;

    tbl[0] = '{4'b0001, 32'h0000000C, 32'h0000000D, 0, 0};
    tbl[1] = '{4'b0110, 32'h00070300, 32'h00090500, 1, 1};
    tbl[2] = '{4'b0110, 32'h00070300, 32'h00090500, 1, 2};
    tbl[3] = '{4'b1001, 32'h0A0000C8, 32'h0B000002, 0, 3};
    tbl[4] = '{4'b1000, 32'hFF000000, 32'hFF000000, 3, 3};
    tbl[5] = '{4'b1010, 32'h01001000, 32'h02001000, 1, 1};
    tbl[6] = '{4'b1111, 32'h04030201, 32'h281E140A, 0, 2};

    // Reset state
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_start", mult_start_o, 0);
    chk("rst_y", y_bo, 0);
    chk("rst_a", mult_a_bo, 0);
    chk("rst_b", mult_b_bo, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // Vector table; entry 0 is the 12*13 single-request case
    for (int i = 0; i < 7; i++) begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
      e = tbl[i].exp_rr;
`else
      e = tbl[i].exp_fp;
`endif
      do_op($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a, tbl[i].b, e);
    end
    chk("tbl0_result_156", prod(tbl[0].a, tbl[0].b, 0), 156);

    // Operands changed and request dropped after grant
    req_i = 4'b0001;
    a_bi  = 32'h000000FF;
    b_bi  = 32'h000000FF;
    e     = model_pick(4'b0001, model_first);
    ok    = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (gnt_o != '0) ok = 1'b1;
    end
    chk("late_gnt_seen", 32'(ok), 1);
    a_bi  = 32'h01010101;
    b_bi  = 32'h02020202;
    req_i = '0;
    wait_done(d, y, ok);
    if (ok) begin
      chk("late_done", d, 32'b0001);
      chk("late_y", y, 65025);
    end
    advance(e);

    // Multiplier busy while idle: nothing issued until busy falls
    force_busy = 1'b1;
    @(negedge clk);
    s0    = start_cnt;
    req_i = 4'b0001;
    a_bi  = 32'h00000021;
    b_bi  = 32'h00000003;
    repeat (20) @(negedge clk);
    chk("busy_idle_no_start", start_cnt - s0, 0);
    chk("busy_idle_gnt", gnt_o, 0);
    force_busy = 1'b0;
    wait_done(d, y, ok);
    req_i = '0;
    if (ok) begin
      chk("busy_idle_done", d, 32'b0001);
      chk("busy_idle_y", y, 99);
      chk("busy_idle_starts", start_cnt - s0, 1);
    end
    advance(0);

    // Held requests from a fresh reset: grant order
    do_reset();
`ifdef MULT_ARB_ROUND_ROBIN_EN
    hreq = 4'b1111;
    hexp = '{0, 1, 2, 3, 0};
`else
    hreq = 4'b0110;
    hexp = '{1, 1, 1, 1, 1};
`endif
    a_bi  = 32'h04030201;
    b_bi  = 32'h281E140A;
    req_i = hreq;
    for (int k = 0; k < 5; k++) begin
      wait_done(d, y, ok);
      if (ok) begin
        chk($sformatf("hold%0d_done", k), d, 32'(1) << hexp[k]);
        chk($sformatf("hold%0d_y", k), y, prod(a_bi, b_bi, hexp[k]));
      end
      advance(hexp[k]);
    end
    req_i = '0;

    // Asynchronous reset during WAIT_DONE
    @(negedge clk);
    @(negedge clk);
    s0    = start_cnt;
    d0    = done_cnt;
    req_i = 4'b0001;
    a_bi  = 32'h00000005;
    b_bi  = 32'h00000007;
    ok    = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (start_cnt != s0) ok = 1'b1;
    end
    chk("rst_op_started", 32'(ok), 1);
    repeat (4) @(negedge clk);
    chk("pre_rst_gnt", gnt_o, 32'b0001);
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_gnt", gnt_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_start", mult_start_o, 0);
    chk("arst_y", y_bo, 0);
    chk("arst_a", mult_a_bo, 0);
    chk("arst_b", mult_b_bo, 0);
    req_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_first = 0;
    repeat (15) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    do_op("post_rst", 4'b0100, 32'h00090000, 32'h00090000, model_pick(4'b0100, model_first));

    // Randomized back-to-back operations against the reference model
    for (int k = 0; k < 40; k++) begin
      r        = 4'($urandom_range(1, 15));
      ra       = $urandom;
      rb       = $urandom;
      busy_len = $urandom_range(1, 6);
      do_op($sformatf("rnd%0d", k), r, ra, rb, model_pick(r, model_first));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
